// File: rtl/alu_mdu.sv
// alu_mdu: single-issue RV ALU with a radix-2 shift-add multiplier and restoring divider.
// Requests use a valid/ready handshake in, and a registered valid/ready result out.
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      funct3,
    input  logic            inst30,
    input  logic [1:0]      aluop,
    input  logic            mext,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_branch,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
    logic [2:0] fn_q, fn_d;
    logic negq_q, negq_d, negr_q, negr_d, br_q, br_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic accept, is_mul, is_div, sgn1, sgn2, div0, ovf, lt, ltu, take;
    logic [XLEN-1:0] m1, m2, sum, diff, alu_r, byp, step_hi, step_lo, quo, rem, fin;
    logic [XLEN:0] msum, rs, rdiff;
    logic [2*XLEN-1:0] prod, sprod;
    logic [SHW-1:0] shamt;

    assign in_ready   = state_q == IDLE || (state_q == DONE && out_ready);
    assign accept     = in_valid && in_ready && !flush;
    assign busy       = state_q == MUL || state_q == DIV;
    assign out_valid  = state_q == DONE;
    assign out_result = res_q;
    assign out_branch = br_q;

    // Operand magnitudes; signedness depends on which M op is requested.
    assign is_mul = aluop == 2'b10 && mext && !funct3[2];
    assign is_div = aluop == 2'b10 && mext && funct3[2];
    assign sgn1   = op1[XLEN-1] && (funct3[2] ? !funct3[0] : funct3[1:0] != 2'b11);
    assign sgn2   = op2[XLEN-1] && (funct3[2] ? !funct3[0] : !funct3[1]);
    assign m1     = sgn1 ? -op1 : op1;
    assign m2     = sgn2 ? -op2 : op2;
    assign div0   = op2 == '0;
    assign ovf    = !funct3[0] && op1 == {1'b1, {(XLEN-1){1'b0}}} && &op2;
    assign byp    = div0 ? (funct3[1] ? op1 : '1) : (funct3[1] ? '0 : op1);

    assign shamt = op2[SHW-1:0];
    assign sum   = op1 + op2;
    assign diff  = op1 - op2;
    assign lt    = $signed(op1) < $signed(op2);
    assign ltu   = op1 < op2;

    always_comb begin
        alu_r = sum;
        if (aluop == 2'b01) begin
            alu_r = {sum[XLEN-1:1], 1'b0};
        end else if (aluop[1]) begin
            case (funct3)
                3'b000:  alu_r = (aluop == 2'b10 && inst30) ? diff : sum;
                3'b001:  alu_r = op1 << shamt;
                3'b010:  alu_r = XLEN'(lt);
                3'b011:  alu_r = XLEN'(ltu);
                3'b100:  alu_r = op1 ^ op2;
                3'b101:  alu_r = inst30 ? XLEN'($signed(op1) >>> shamt) : op1 >> shamt;
                3'b110:  alu_r = op1 | op2;
                default: alu_r = op1 & op2;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  take = op1 == op2;
            3'b001:  take = op1 != op2;
            3'b100:  take = lt;
            3'b101:  take = !lt;
            3'b110:  take = ltu;
            3'b111:  take = !ltu;
            default: take = 1'b0;
        endcase
    end

    // hi/lo are shared: product high/multiplier for MUL, remainder/quotient for DIV.
    assign msum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign rs      = {hi_q, lo_q[XLEN-1]};
    assign rdiff   = rs - {1'b0, a_q};
    assign step_hi = state_q == MUL ? msum[XLEN:1] : (rdiff[XLEN] ? rs[XLEN-1:0] : rdiff[XLEN-1:0]);
    assign step_lo = state_q == MUL ? {msum[0], lo_q[XLEN-1:1]} : {lo_q[XLEN-2:0], !rdiff[XLEN]};
    assign prod    = {step_hi, step_lo};
    assign sprod   = negq_q ? -prod : prod;
    assign quo     = negq_q ? -step_lo : step_lo;
    assign rem     = negr_q ? -step_hi : step_hi;
    assign fin     = state_q == MUL ? (fn_q[1:0] == 2'b00 ? sprod[XLEN-1:0] : sprod[2*XLEN-1:XLEN])
                                    : (fn_q[1] ? rem : quo);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        br_d    = br_q;
        fn_d    = fn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            fn_d  = funct3;
            br_d  = 1'b0;
            cnt_d = '0;
            if (is_mul) begin
                state_d = MUL;
                a_d     = m1;
                hi_d    = '0;
                lo_d    = m2;
                negq_d  = sgn1 ^ sgn2;
            end else if (is_div && !div0 && !ovf) begin
                state_d = DIV;
                a_d     = m2;
                hi_d    = '0;
                lo_d    = m1;
                negq_d  = sgn1 ^ sgn2;
                negr_d  = sgn1;
            end else begin
                state_d = DONE;
                res_d   = is_div ? byp : alu_r;
                br_d    = aluop == 2'b01 && take;
            end
        end else if (busy) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHW'(XLEN-1)) begin
                state_d = DONE;
                res_d   = fin;
                cnt_d   = '0;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            fn_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            br_q    <= br_d;
            fn_q    <= fn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed and random checks of alu_mdu against a plain-arithmetic model.
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, inst30 = 1'b0, mext = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  aluop = '0;
    logic        in_ready, out_valid, out_branch, busy;
    logic [31:0] out_result;
    int checks = 0, failures = 0;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .funct3(funct3), .inst30(inst30), .aluop(aluop),
        .mext(mext), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_branch(out_branch), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] a, b, input logic [2:0] f3,
                                          input logic i30, input logic [1:0] aop, input logic m);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic br, ov;
        logic [4:0] sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ov = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        sh = b[4:0];
        br = 1'b0;
        r  = a + b;
        p  = '0;
        if (aop == 2'b01) begin
            r = (a + b) & 32'hFFFF_FFFE;
            case (f3)
                3'd0: br = a == b;
                3'd1: br = a != b;
                3'd4: br = sa < sb;
                3'd5: br = sa >= sb;
                3'd6: br = a < b;
                3'd7: br = a >= b;
                default: br = 1'b0;
            endcase
        end else if (aop == 2'b10 && m) begin
            case (f3)
                3'd0: begin p = sa * sb; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * ub; r = p[63:32]; end
                3'd3: begin p = ua * ub; r = p[63:32]; end
                3'd4: r = b == 0 ? 32'hFFFF_FFFF : ov ? a : 32'(sa / sb);
                3'd5: r = b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
                3'd6: r = b == 0 ? a : ov ? 32'd0 : 32'(sa % sb);
                default: r = b == 0 ? a : 32'(ua % ub);
            endcase
        end else if (aop[1]) begin
            case (f3)
                3'd0: r = (aop == 2'b10 && i30) ? a - b : a + b;
                3'd1: r = a << sh;
                3'd2: r = {31'd0, sa < sb};
                3'd3: r = {31'd0, a < b};
                3'd4: r = a ^ b;
                3'd5: r = i30 ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return {br, r};
    endfunction

    function automatic int exp_lat(input logic [31:0] a, b, input logic [2:0] f3,
                                   input logic [1:0] aop, input logic m);
        if (!(aop == 2'b10 && m)) return 1;
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    task automatic drive(input logic [31:0] a, b, input logic [2:0] f3, input logic i30,
                         input logic [1:0] aop, input logic m);
        op1 = a; op2 = b; funct3 = f3; inst30 = i30; aluop = aop; mext = m; in_valid = 1'b1;
    endtask

    // Inputs are scrambled after acceptance so only latched operands can matter.
    task automatic issue_wait(input logic [31:0] a, b, input logic [2:0] f3, input logic i30,
                              input logic [1:0] aop, input logic m,
                              output logic [31:0] r, output logic br, output int lat, output int bc);
        @(negedge clk);
        drive(a, b, f3, i30, aop, m);
        out_ready = 1'b0;
        #1 chk("in_ready_at_issue", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom); inst30 = 1'($urandom);
        aluop = 2'($urandom); mext = 1'($urandom);
        lat = 1;
        bc = int'(busy);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            bc += int'(busy);
        end
        r  = out_result;
        br = out_branch;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("valid_drops_after_take", out_valid, 0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, b, input logic [2:0] f3,
                         input logic i30, input logic [1:0] aop, input logic m);
        logic [32:0] e;
        logic [31:0] r;
        logic br;
        int lat, bc;
        e = model(a, b, f3, i30, aop, m);
        issue_wait(a, b, f3, i30, aop, m, r, br, lat, bc);
        chk({tag, "_result"}, r, e[31:0]);
        chk({tag, "_branch"}, 32'(br), 32'(e[32]));
        chk({tag, "_latency"}, lat, exp_lat(a, b, f3, aop, m));
        consume();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r, held;
        logic br;
        int lat, bc, seen, stable, rdy;
        logic [1:0] aop;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_branch", out_branch, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);

        do_op("add_5_m3", 32'd5, 32'hFFFF_FFFD, 3'b000, 1'b0, 2'b10, 1'b0);
        do_op("sub", 32'd5, 32'd9, 3'b000, 1'b1, 2'b10, 1'b0);
        do_op("bltu", 32'd1, 32'hFFFF_FFFF, 3'b110, 1'b0, 2'b01, 1'b0);
        do_op("sra", 32'h8000_00F0, 32'd4, 3'b101, 1'b1, 2'b11, 1'b0);

        issue_wait(32'h8000_0000, 32'h8000_0000, 3'b001, 1'b0, 2'b10, 1'b1, r, br, lat, bc);
        chk("mulh_result", r, 32'h4000_0000);
        chk("mulh_latency", lat, 33);
        chk("mulh_busy_cycles", bc, 32);
        consume();

        do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 3'b100, 1'b0, 2'b10, 1'b1);
        do_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 3'b110, 1'b0, 2'b10, 1'b1);
        do_op("div_5_0", 32'd5, 32'd0, 3'b100, 1'b0, 2'b10, 1'b1);
        do_op("rem_5_0", 32'd5, 32'd0, 3'b110, 1'b0, 2'b10, 1'b1);
        do_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 1'b0, 2'b10, 1'b1);
        do_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 1'b0, 2'b10, 1'b1);

        // Backpressure: result must hold while out_ready is low, then back-to-back accept.
        issue_wait(32'h1234, 32'h0F0F, 3'b110, 1'b0, 2'b10, 1'b0, r, br, lat, bc);
        held = r;
        chk("hold_first_result", r, 32'h1F3F);
        stable = 1;
        rdy = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_result !== held || out_valid !== 1'b1) stable = 0;
            if (in_ready) rdy = 1;
        end
        chk("hold_stable", stable, 1);
        chk("hold_in_ready_low", rdy, 0);
        @(negedge clk);
        drive(32'd7, 32'd3, 3'b100, 1'b0, 2'b10, 1'b0);
        out_ready = 1'b1;
        #1 chk("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_result", out_result, 32'd4);
        consume();

        // Flush five cycles into a divide.
        @(negedge clk);
        drive(32'hFFFF_FFF9, 32'd2, 3'b100, 1'b0, 2'b10, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        chk("flush_no_result", seen, 0);

        // Flush wins over a simultaneous accept.
        @(negedge clk);
        drive(32'd1, 32'd2, 3'b000, 1'b0, 2'b10, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_drops_request", out_valid, 0);

        // Flush discards a waiting result.
        issue_wait(32'd3, 32'd4, 3'b000, 1'b0, 2'b00, 1'b0, r, br, lat, bc);
        chk("pre_flush_done", r, 32'd7);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_done_discard", out_valid, 0);
        do_op("after_flush_add", 32'd100, 32'd23, 3'b000, 1'b0, 2'b10, 1'b0);

        // Asynchronous reset five cycles into a multiply.
        @(negedge clk);
        drive(32'd1234, 32'd5678, 3'b000, 1'b0, 2'b10, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("midrst_in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        chk("midrst_no_result", seen, 0);
        do_op("after_rst_add", 32'hFFFF_FFFF, 32'd2, 3'b000, 1'b0, 2'b10, 1'b0);

        for (int i = 0; i < 200; i++) begin
            aop = 2'($urandom_range(0, 3));
            do_op("rand", pick(), pick(), 3'($urandom), 1'($urandom), aop,
                  aop == 2'b10 ? 1'($urandom) : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
